// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory refill path.
//   BLOCK_WORDS     : 32-bit words per cache block
//   WORDS_PER_CYCLE : words delivered per memory beat
//   BLOCK_OFFSET_W  : byte-offset bits inside one block (cleared in refill addresses)
//   arb_state_t     : refill arbiter state encoding
package mem_pkg;

    localparam int BLOCK_WORDS     = 16;
    localparam int WORDS_PER_CYCLE = 2;
    localparam int BLOCK_OFFSET_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req : request vector, one bit per requester
//   ptr : index of the requester with highest priority this cycle
//   gnt : one-hot winner (all zero when no request is set)
// The search starts at ptr and wraps around; the pointer register itself
// lives in the parent so this block stays stateless.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares the single main-memory refill port between NUM_REQ L1 requesters
// (port 0 = instruction cache, port 1 = data cache).
//
// Ports:
//   clk_i        : clock, rising edge
//   reset_ni     : asynchronous active-low reset
//   req_i        : refill request per requester
//   req_addr_i   : miss address per requester
//   grant_o      : one-hot owner of the memory port
//   rsp_valid_o  : beat valid for requester n this cycle
//   rsp_beat_o   : index of the current beat (word offset = beat*WORDS_PER_CYCLE)
//   rsp_data_o   : beat data {word[2k+1], word[2k]}
//   done_o       : one-cycle pulse on the final beat of requester n's burst
//   mem_req_o    : memory request active
//   mem_addr_o   : block-aligned refill address
//   mem_ready_i  : memory beat valid
//   mem_data_i   : memory beat data
//   state_o      : current arbiter state (arb_state_t encoding)
//
// Handshake: a requester raises req_i and holds it until its done_o pulse;
// the request is sampled only in IDLE, so dropping it later has no effect.
// Toward memory, mem_req_o stays high for the whole burst and every cycle
// with mem_ready_i=1 in XFER is exactly one beat; mem_ready_i is a
// valid-only strobe (no back-pressure), ignored outside XFER.
module mem_refill_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int BLOCK_WORDS     = mem_pkg::BLOCK_WORDS,
    parameter int WORDS_PER_CYCLE = mem_pkg::WORDS_PER_CYCLE,
    localparam int BEATS          = BLOCK_WORDS / WORDS_PER_CYCLE,
    localparam int BEAT_W         = $clog2(BEATS)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [31:0]        req_addr_i [NUM_REQ],
    output logic [NUM_REQ-1:0] grant_o,
    output logic [NUM_REQ-1:0] rsp_valid_o,
    output logic [BEAT_W-1:0]  rsp_beat_o,
    output logic [63:0]        rsp_data_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    input  logic               mem_ready_i,
    input  logic [63:0]        mem_data_i,
    output logic [1:0]         state_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // One spare bit so an out-of-range count is representable and checkable.
    localparam int CNT_W = BEAT_W + 1;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << BLOCK_OFFSET_W) - 32'd1);

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] winner;
    logic [31:0]        win_addr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               beat;
    logic               last_beat;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (winner)
    );

    always_comb begin
        win_addr  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_addr = req_addr_i[i];
            if (grant[i])  grant_idx = PTR_W'(i);
        end
        // Requester after the current owner gets first pick next time.
        next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    assign beat      = (state == XFER) && mem_ready_i;
    assign last_beat = beat && (beat_cnt == CNT_W'(BEATS - 1));

    assign grant_o     = grant;
    assign mem_req_o   = mem_req;
    assign mem_addr_o  = mem_addr;
    assign rsp_valid_o = beat ? grant : '0;
    assign done_o      = last_beat ? grant : '0;
    assign rsp_beat_o  = (state == XFER) ? beat_cnt[BEAT_W-1:0] : '0;
    assign rsp_data_o  = mem_data_i;
    assign state_o     = state;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            grant    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        grant    <= winner;
                        mem_addr <= win_addr & ADDR_MASK;
                        beat_cnt <= '0;
                        mem_req  <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        // Counter is left at BEATS-1; it restarts at the next grant.
                        grant   <= '0;
                        mem_req <= 1'b0;
                        rr_ptr  <= next_ptr;
                        state   <= RELEASE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    beat_cnt_in_range: assert property (
        @(posedge clk_i) disable iff (!reset_ni) beat_cnt < CNT_W'(BEATS)
    );

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: reset state, single refill,
// round-robin order, stalls, fairness under load, reset mid-burst,
// request drop / address change after grant.
module tb_mem_refill_arbiter;
    import mem_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int BEATS   = 8;
    localparam int BEAT_W  = 3;

    logic               clk_i = 1'b0;
    logic               reset_ni;
    logic [NUM_REQ-1:0] req_i;
    logic [31:0]        req_addr_i [NUM_REQ];
    logic [NUM_REQ-1:0] grant_o;
    logic [NUM_REQ-1:0] rsp_valid_o;
    logic [BEAT_W-1:0]  rsp_beat_o;
    logic [63:0]        rsp_data_o;
    logic [NUM_REQ-1:0] done_o;
    logic               mem_req_o;
    logic [31:0]        mem_addr_o;
    logic               mem_ready_i;
    logic [63:0]        mem_data_i;
    logic [1:0]         state_o;

    int total = 0;
    int bad   = 0;

    mem_refill_arbiter dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .req_i       (req_i),
        .req_addr_i  (req_addr_i),
        .grant_o     (grant_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_beat_o  (rsp_beat_o),
        .rsp_data_o  (rsp_data_o),
        .done_o      (done_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready_i),
        .mem_data_i  (mem_data_i),
        .state_o     (state_o)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        #1;
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_req", 64'(mem_req_o), 64'(0));
        chk("rst_state", 64'(state_o), 64'(IDLE));
        step();
        reset_ni = 1'b1;
    endtask

    // Drives one full burst starting in the first XFER cycle and checks every
    // beat; ends in the RELEASE cycle. With stall set, two dead cycles are
    // inserted before every odd beat (ready pattern 1,0,0,1,1,0,0,1,...).
    // At beat drop_at all requests are dropped and addresses scrambled.
    task automatic burst(input logic [1:0] g, input logic [31:0] addr,
                         input bit stall, input int drop_at);
        int seen = 0;
        logic [63:0] d;
        for (int b = 0; b < BEATS; b++) begin
            if (stall && (b % 2 == 1)) begin
                for (int s = 0; s < 2; s++) begin
                    mem_ready_i = 1'b0;
                    mem_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
                    #1;
                    if (rsp_valid_o != 2'b00) seen++;
                    chk("stall_valid", 64'(rsp_valid_o), 64'(0));
                    chk("stall_beat", 64'(rsp_beat_o), 64'(b));
                    chk("stall_done", 64'(done_o), 64'(0));
                    step();
                end
            end
            if (b == drop_at) begin
                req_i         = 2'b00;
                req_addr_i[0] = 32'hFFFF_FFFF;
                req_addr_i[1] = 32'hFFFF_FFFF;
            end
            d = {8'(g), 24'(2 * b + 1), 8'(g), 24'(2 * b)};
            mem_ready_i = 1'b1;
            mem_data_i  = d;
            #1;
            if (rsp_valid_o != 2'b00) seen++;
            chk("beat_valid", 64'(rsp_valid_o), 64'(g));
            chk("beat_idx", 64'(rsp_beat_o), 64'(b));
            chk("beat_data", rsp_data_o, d);
            chk("beat_done", 64'(done_o), (b == BEATS - 1) ? 64'(g) : 64'(0));
            chk("beat_req", 64'(mem_req_o), 64'(1));
            chk("beat_addr", 64'(mem_addr_o), 64'(addr));
            chk("beat_grant", 64'(grant_o), 64'(g));
            step();
        end
        // RELEASE cycle: a ready strobe here must produce nothing.
        mem_ready_i = 1'b1;
        mem_data_i  = '0;
        #1;
        chk("rel_state", 64'(state_o), 64'(RELEASE));
        chk("rel_req", 64'(mem_req_o), 64'(0));
        chk("rel_grant", 64'(grant_o), 64'(0));
        chk("rel_valid", 64'(rsp_valid_o), 64'(0));
        chk("rel_done", 64'(done_o), 64'(0));
        chk("beat_count", 64'(seen), 64'(BEATS));
        mem_ready_i = 1'b0;
    endtask

    logic [1:0] t4_exp [4];

    initial begin
        reset_ni      = 1'b0;
        req_i         = '0;
        req_addr_i[0] = '0;
        req_addr_i[1] = '0;
        mem_ready_i   = 1'b0;
        mem_data_i    = '0;
        t4_exp        = '{2'b01, 2'b10, 2'b01, 2'b10};
        #1;
        chk("reset_grant", 64'(grant_o), 64'(0));
        chk("reset_mem_req", 64'(mem_req_o), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr_o), 64'(0));
        chk("reset_state", 64'(state_o), 64'(IDLE));
        chk("reset_valid", 64'(rsp_valid_o), 64'(0));
        chk("reset_done", 64'(done_o), 64'(0));
        chk("reset_beat", 64'(rsp_beat_o), 64'(0));
        step();
        step();
        reset_ni = 1'b1;

        // ready strobe while idle is ignored
        mem_ready_i = 1'b1;
        #1;
        chk("idle_valid", 64'(rsp_valid_o), 64'(0));
        step();
        chk("idle_state", 64'(state_o), 64'(IDLE));
        chk("idle_req", 64'(mem_req_o), 64'(0));
        mem_ready_i = 1'b0;

        // 1: single icache miss, no stall
        req_i         = 2'b01;
        req_addr_i[0] = 32'h0000_1234;
        step();
        chk("t1_grant", 64'(grant_o), 64'(2'b01));
        chk("t1_addr", 64'(mem_addr_o), 64'(32'h0000_1200));
        chk("t1_req", 64'(mem_req_o), 64'(1));
        chk("t1_state", 64'(state_o), 64'(XFER));
        burst(2'b01, 32'h0000_1200, 1'b0, -1);
        req_i = 2'b00;
        step();
        chk("t1_idle_state", 64'(state_o), 64'(IDLE));
        chk("t1_idle_req", 64'(mem_req_o), 64'(0));
        step();
        chk("t1_no_regrant", 64'(grant_o), 64'(0));

        // 2: simultaneous requests after reset, twice
        do_reset();
        req_i         = 2'b11;
        req_addr_i[0] = 32'h0000_2040;
        req_addr_i[1] = 32'h0001_3F88;
        for (int r = 0; r < 2; r++) begin
            step();
            chk("t2_first_grant", 64'(grant_o), 64'(2'b01));
            chk("t2_first_addr", 64'(mem_addr_o), 64'(32'h0000_2040));
            burst(2'b01, 32'h0000_2040, 1'b0, -1);
            req_i = 2'b10;
            step();
            chk("t2_gap_req", 64'(mem_req_o), 64'(0));
            chk("t2_gap_grant", 64'(grant_o), 64'(0));
            step();
            chk("t2_second_grant", 64'(grant_o), 64'(2'b10));
            chk("t2_second_addr", 64'(mem_addr_o), 64'(32'h0001_3F80));
            burst(2'b10, 32'h0001_3F80, 1'b0, -1);
            req_i = 2'b11;
            step();
        end
        req_i = 2'b00;
        step();

        // 3: stalls (pointer is 0 here)
        req_i         = 2'b01;
        req_addr_i[0] = 32'hABCD_EF7F;
        step();
        chk("t3_grant", 64'(grant_o), 64'(2'b01));
        chk("t3_addr", 64'(mem_addr_o), 64'(32'hABCD_EF40));
        burst(2'b01, 32'hABCD_EF40, 1'b1, -1);
        req_i = 2'b00;
        step();
        step();

        // 4: fairness under continuous load
        do_reset();
        req_i         = 2'b11;
        req_addr_i[0] = 32'h0000_0100;
        req_addr_i[1] = 32'h0000_02FF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_grant", 64'(grant_o), 64'(t4_exp[k]));
            burst(t4_exp[k], (t4_exp[k] == 2'b01) ? 32'h0000_0100 : 32'h0000_02C0, 1'b0, -1);
            step();
            chk("t4_gap_req", 64'(mem_req_o), 64'(0));
            chk("t4_gap_state", 64'(state_o), 64'(IDLE));
        end
        req_i = 2'b00;
        step();
        chk("t4_idle", 64'(grant_o), 64'(0));

        // 5: reset mid-burst (pointer is 0 here)
        req_i         = 2'b01;
        req_addr_i[0] = 32'h0000_5555;
        step();
        chk("t5_grant", 64'(grant_o), 64'(2'b01));
        for (int b = 0; b < 4; b++) begin
            mem_ready_i = 1'b1;
            mem_data_i  = 64'(b);
            #1;
            chk("t5_beat_idx", 64'(rsp_beat_o), 64'(b));
            chk("t5_beat_valid", 64'(rsp_valid_o), 64'(2'b01));
            chk("t5_beat_done", 64'(done_o), 64'(0));
            step();
        end
        reset_ni = 1'b0;
        #1;
        chk("t5_rst_grant", 64'(grant_o), 64'(0));
        chk("t5_rst_req", 64'(mem_req_o), 64'(0));
        chk("t5_rst_valid", 64'(rsp_valid_o), 64'(0));
        chk("t5_rst_done", 64'(done_o), 64'(0));
        chk("t5_rst_state", 64'(state_o), 64'(IDLE));
        step();
        chk("t5_held_done", 64'(done_o), 64'(0));
        reset_ni    = 1'b1;
        mem_ready_i = 1'b0;
        step();
        chk("t5_regrant", 64'(grant_o), 64'(2'b01));
        chk("t5_regrant_beat", 64'(rsp_beat_o), 64'(0));
        burst(2'b01, 32'h0000_5540, 1'b0, -1);
        req_i = 2'b00;
        step();
        step();

        // 6: request drop and address change after grant (pointer is 1 here)
        req_i         = 2'b10;
        req_addr_i[1] = 32'h8000_0FC4;
        step();
        chk("t6_grant", 64'(grant_o), 64'(2'b10));
        chk("t6_addr", 64'(mem_addr_o), 64'(32'h8000_0FC0));
        burst(2'b10, 32'h8000_0FC0, 1'b0, 2);
        step();
        chk("t6_idle_state", 64'(state_o), 64'(IDLE));
        step();
        chk("t6_no_regrant", 64'(grant_o), 64'(0));
        chk("t6_no_req", 64'(mem_req_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
Shares the single main-memory refill port between NUM_REQ cache requesters (port 0 = instruction cache, port 1 = data cache). It arbitrates round-robin, latches the winner's block-aligned address and drives the memory request. It then counts the BEATS beats of the block burst and steers each beat and its index back to the granted requester. It sits between the L1 caches and main memory.

Parameters:
NUM_REQ, 2, number of requesters (min 2)
BLOCK_WORDS, 16, 32-bit words per cache block
WORDS_PER_CYCLE, 2, words delivered per memory beat
BEATS, BLOCK_WORDS/WORDS_PER_CYCLE (8), derived localparam, beats per burst
BEAT_W, $clog2(BEATS) (3), derived localparam, beat index width

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  refill request per requester; held high until its done pulse
req_addr_i  in  NUM_REQ x 32  miss address per requester (unpacked array)
grant_o  out  NUM_REQ  one-hot; requester currently owning memory
rsp_valid_o  out  NUM_REQ  beat valid for requester n this cycle
rsp_beat_o  out  BEAT_W  index of the current beat (word offset = beat*WORDS_PER_CYCLE)
rsp_data_o  out  64  beat data, {word[2k+1], word[2k]}
done_o  out  NUM_REQ  one-cycle pulse on the final beat of requester n's burst
mem_req_o  out  1  memory request active
mem_addr_o  out  32  block-aligned address, low log2(BLOCK_WORDS*4) bits = 0
mem_ready_i  in  1  memory beat valid
mem_data_i  in  64  memory beat data

Behaviour:
- Reset (reset_ni=0, asynchronous): state=IDLE, grant_o=0, mem_req_o=0, mem_addr_o=0, beat counter=0, rr pointer=0 (port 0 highest priority next). A reset mid-burst abandons the burst with no done pulse.
- States:
  - IDLE: if any req_i is set, pick a winner round-robin starting at the rr pointer. Register grant_o (one-hot), latch mem_addr_o = req_addr_i[w] with low 6 bits cleared, clear the beat counter, set mem_req_o=1, go to XFER. If no req_i is set, stay in IDLE.
  - XFER: mem_req_o=1. Each cycle mem_ready_i=1 is one beat:
    - rsp_valid_o = grant_o (combinational), rsp_beat_o = counter, rsp_data_o = mem_data_i (combinational pass-through). Counter increments.
    - Cycles with mem_ready_i=0 are stalls: no beat, counter holds.
    - On the beat with counter==BEATS-1: done_o[w]=1 (combinational on that beat). Next cycle, state=RELEASE and mem_req_o=0.
  - RELEASE: one cycle. grant_o=0, mem_req_o=0, rr pointer = w+1 mod NUM_REQ. Go to IDLE. This guarantees memory sees a deasserted request between bursts.
- Latency: req_i rising in IDLE gives grant_o and mem_req_o the next cycle. Minimum request-to-done is 1+BEATS cycles. Back-to-back bursts are separated by 2 idle cycles on mem_req_o (RELEASE, IDLE).
- Simultaneous requests: only the pointer-ordered winner is granted. Losers keep req_i high and wait. No requester waits more than NUM_REQ-1 bursts.
- A requester dropping req_i mid-burst is ignored: the burst completes and done still pulses.
- Address changes on req_addr_i after the grant are ignored; the latched mem_addr_o is used.
- rsp_valid_o, done_o and rsp_beat_o are 0 outside XFER. rsp_data_o is don't-care when no beat is valid.
- The beat counter wraps only via reset to 0 at a new grant. A counter value ≥ BEATS is unreachable; assert on it in simulation.
- mem_ready_i in IDLE or RELEASE is ignored.

Decomposition:
- Shared package mem_pkg:
  - BLOCK_WORDS and WORDS_PER_CYCLE constants
  - BLOCK_OFFSET_W = 6
  - refill state enum arb_state_t {IDLE, XFER, RELEASE}, 2 bits
- One natural sub-module: rr_arbiter (parameter N). Inputs: req vector, pointer. Output: one-hot winner. Purely combinational; the pointer register stays in the parent.

Test Plan:
1. Single icache miss, no stall: req_i=01, req_addr_i[0]=0x0000_1234 -> next cycle grant_o=01 and mem_addr_o=0x0000_1200. With mem_ready_i=1 each cycle, beats 0..7 each raise rsp_valid_o=01; done_o=01 on beat 7; mem_req_o=0 the following cycle.
2. Simultaneous requests after reset: req_i=11 -> port 0 served first, then port 1, with rr pointer=1 after the first burst. Repeat with req_i=11 again -> port 0 goes first again, since the pointer wrapped to 0.
3. Stalls: mem_ready_i pattern 1,0,0,1,... -> rsp_beat_o increments only on ready cycles. done_o still fires exactly on the 8th ready beat, and total beats = 8.
4. Fairness under continuous load: both req_i held high for 4 bursts -> grants alternate 01,10,01,10. mem_req_o is low for exactly 2 cycles between bursts.
5. Reset mid-burst: assert reset_ni=0 after beat 3 -> grant_o, mem_req_o and rsp_valid_o go to 0 without waiting for a clock edge. No done_o pulse. After release, a pending req is re-granted from beat 0.
6. Request drop and address change: port 1 granted; deassert req_i[1] and change req_addr_i[1] at beat 2 -> mem_addr_o unchanged, all 8 beats delivered, done_o=10 pulses.
